// File: rtl/arb_pkg.sv
// Shared constants and state type for the round-robin arbiter family.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

endpackage

// File: rtl/dec3x8.sv
// 3-to-8 one-hot decoder.
module dec3x8 (
    input  logic [2:0] A,
    output logic [7:0] Y
);

    // Shift a single one into the selected position.
    always_comb begin
        Y = 8'b0000_0001 << A;
    end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with a hold timer that revokes long grants.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic             done,
    output logic [7:0]       grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // HOLD_MAX = 0 disables the timer; keep a 1-bit counter so the width stays legal.
    localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]   pick;
    logic               hold_limit;
    logic               owner_drop;
    logic [N_REQ-1:0]   dec_y;

    // First set request at or above p, wrapping modulo N_REQ, via a doubled vector.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   win;
        logic [IDX_W-1:0]   off;
        dbl = {r, r};
        win = N_REQ'(dbl >> p);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (win[i]) begin
                off = IDX_W'(i);
            end
        end
        return p + off;
    endfunction

    // Next-state logic: select in IDLE, release or count in GRANT.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        pick       = rr_pick(req, ptr_q);
        hold_limit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
        owner_drop = !req[idx_q];

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    idx_d      = pick;
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (done || owner_drop || hold_limit) begin
                    valid_d    = 1'b0;
                    ptr_d      = idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                    // Only flag a timeout when the timer alone ended the grant.
                    timeout_d  = hold_limit && !done && !owner_drop;
                end else if (HOLD_MAX != 0) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    dec3x8 u_dec (
        .A (idx_q),
        .Y (dec_y)
    );

    // One-hot grant gated by the registered valid flag.
    always_comb begin
        grant = dec_y & {N_REQ{valid_q}};
    end

    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: vector table plus hand-written corner sequences.
module tb_rr_arb8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        logic       rn;
        logic [7:0] r;
        logic       d;
        logic [7:0] eg;
        logic       ev;
        logic [2:0] ei;
        logic       et;
    } vec_t;

    typedef struct {
        logic [7:0] eg;
        logic       ev;
        logic [2:0] ei;
        logic       et;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    rr_arb8 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h required %h", step_no, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic rn, input logic [7:0] r, input logic d,
                        input logic [7:0] eg, input logic ev, input logic [2:0] ei,
                        input logic et);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n = rn;
        req   = r;
        done  = d;
        e.eg = eg;
        e.ev = ev;
        e.ei = ei;
        e.et = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step %0d scoreboard: got empty queue required an entry", step_no);
        end else begin
            got = exp_q.pop_front();
            cmp("grant", grant, got.eg);
            cmp("grant_valid", {7'd0, grant_valid}, {7'd0, got.ev});
            cmp("grant_idx", {5'd0, grant_idx}, {5'd0, got.ei});
            cmp("timeout", {7'd0, timeout}, {7'd0, got.et});
        end
    endtask

    task automatic add(input logic rn, input logic [7:0] r, input logic d,
                       input logic [7:0] eg, input logic ev, input logic [2:0] ei,
                       input logic et);
        vec_t v;
        v.rn = rn; v.r = r; v.d = d; v.eg = eg; v.ev = ev; v.ei = ei; v.et = et;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;

        // Reset held two cycles with all requests up.
        add(0, 8'hFF, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'hFF, 0, 8'h00, 0, 3'd0, 0);
        // Rotation 0..7,0 with done on each grant's first cycle and one idle gap.
        for (int k = 0; k < 9; k++) begin
            add(1, 8'hFF, 0, 8'h01 << (k % 8), 1, 3'(k % 8), 0);
            add(1, 8'hFF, 1, 8'h00, 0, 3'(k % 8), 0);
        end
        // Pointer now 1: grant 2, release, then 0101 must wrap to 0.
        add(1, 8'h04, 0, 8'h04, 1, 3'd2, 0);
        add(1, 8'h04, 1, 8'h00, 0, 3'd2, 0);
        add(1, 8'h05, 0, 8'h01, 1, 3'd0, 0);
        add(1, 8'h05, 1, 8'h00, 0, 3'd0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rn, vecs[i].r, vecs[i].d, vecs[i].eg, vecs[i].ev,
                 vecs[i].ei, vecs[i].et);
        end

        // Timeout: owner 3 holds four cycles, then a one-cycle timeout in the idle gap.
        step(1, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        for (int k = 0; k < 3; k++) step(1, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        step(1, 8'h08, 0, 8'h00, 0, 3'd3, 1);
        step(1, 8'h08, 0, 8'h08, 1, 3'd3, 0);

        // done coinciding with the timer limit on the fourth grant cycle: no timeout.
        for (int k = 0; k < 3; k++) step(1, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        step(1, 8'h08, 1, 8'h00, 0, 3'd3, 0);

        // Dropped request releases next cycle with no timeout.
        step(1, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        step(1, 8'h00, 0, 8'h00, 0, 3'd3, 0);
        // done while idle does nothing.
        step(1, 8'h00, 1, 8'h00, 0, 3'd3, 0);

        // Reset mid-grant: grant drops, pointer returns to 0.
        step(1, 8'h20, 0, 8'h20, 1, 3'd5, 0);
        step(0, 8'hFF, 0, 8'h00, 0, 3'd0, 0);
        step(1, 8'hFF, 0, 8'h01, 1, 3'd0, 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d left required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
